// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions for the fetch stage: the default bus geometry,
// the fetch FSM encoding and the canonical NOP word.
package instr_fetch_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DEPTH_DEFAULT  = 64;

  // addi x0, x0, 0 -- what a bubble looks like when decode wants a real word
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory port, control inputs from the core and
// the valid/ready output towards decode.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt_req;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;

  // The fetch unit itself sits on the slave side of this bus
  modport slave (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport master (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, combinational memory read and a
// single registered output slot with valid/ready backpressure.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_fetch_if.slave bus
);

  localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] redirect_target;
  logic              fire;
  logic              halted;
  logic              held_valid;
  logic [31:0]       held_instr;
  logic [ADDR_W-1:0] held_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A redirect always lands in RUN, whatever state we were in
  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_RUN;
        ST_RUN:  state_next = bus.halt_req ? ST_HALT : ST_RUN;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fire   = 1'b0;
    halted = 1'b0;
    case (state)
      ST_RUN:  fire = !bus.redirect_valid && !bus.halt_req &&
                      (!held_valid || bus.out_ready);
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // The modulo is widened by one bit so DEPTH == 2**ADDR_W stays representable
  always_comb begin
    pc_plus         = (pc == PC_LAST) ? '0 : pc + ADDR_W'(1);
    redirect_target = ADDR_W'({1'b0, bus.redirect_pc} % DEPTH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= PC_RESET;
      held_valid <= 1'b0;
      held_instr <= '0;
      held_pc    <= '0;
    end else if (bus.redirect_valid) begin
      pc         <= redirect_target;
      held_valid <= 1'b0;
    end else if (fire) begin
      held_instr <= bus.imem_data;
      held_pc    <= pc;
      held_valid <= 1'b1;
      pc         <= pc_plus;
    end else if (held_valid && bus.out_ready) begin
      held_valid <= 1'b0;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.out_valid = held_valid;
  assign bus.out_instr = held_instr;
  assign bus.out_pc    = held_pc;
  assign bus.halted    = halted;

  // A stalled output must not move until decode takes it or a redirect flushes it
  property p_stall_holds;
    @(posedge clk) disable iff (!rst_n)
      (held_valid && !bus.out_ready && !bus.redirect_valid) |=>
        (held_valid && $stable(held_pc) && $stable(held_instr));
  endproperty
  a_stall_holds: assert property (p_stall_holds);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// phase, all compared against a transaction-level reference model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int DEPTH    = 64;
  localparam int RESET_PC = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  logic [31:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr];

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: 0 = waiting out the post-reset cycle, 1 = fetching, 2 = halted
  int          m_mode;
  int          m_pc;
  bit          m_valid;
  int          m_out_pc;
  logic [31:0] m_instr;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_pc     = RESET_PC;
    m_valid  = 1'b0;
    m_out_pc = 0;
    m_instr  = '0;
  endtask

  task automatic model_step(input bit red, input int rpc, input bit halt, input bit rdy);
    if (red) begin
      m_pc    = rpc % DEPTH;
      m_valid = 1'b0;
      m_mode  = 1;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && !halt && (!m_valid || rdy)) begin
      m_instr  = mem[m_pc];
      m_out_pc = m_pc;
      m_valid  = 1'b1;
      m_pc     = (m_pc + 1) % DEPTH;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (m_mode == 1 && halt) m_mode = 2;
    end
  endtask

  task automatic check_all();
    check_output("out_valid", bus.out_valid, m_valid);
    check_output("halted", bus.halted, m_mode == 2);
    check_output("imem_addr", bus.imem_addr, m_pc);
    if (m_valid) begin
      check_output("out_pc", bus.out_pc, m_out_pc);
      check_output("out_instr", bus.out_instr, m_instr);
    end
  endtask

  // Called at a falling edge; inputs apply to the next rising edge
  task automatic apply_stimulus(input bit red, input int rpc, input bit halt, input bit rdy);
    bus.redirect_valid = red;
    bus.redirect_pc    = ADDR_W'(rpc);
    bus.halt_req       = halt;
    bus.out_ready      = rdy;
    if (rst_n) model_step(red, rpc, halt, rdy);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (m_valid && m_out_pc == target) break;
      apply_stimulus(0, 0, 0, 1);
    end
    check_output("reach_pc", bus.out_pc, target);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_output("rst_valid", bus.out_valid, 0);
    check_output("rst_pc", bus.out_pc, 0);
    check_output("rst_instr", bus.out_instr, 0);
    check_output("rst_halted", bus.halted, 0);
    check_output("rst_addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq[6];
    seq = '{60, 61, 62, 63, 0, 1};
    for (int k = 0; k < 256; k++) mem[k] = 32'(k);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt_req       = 1'b0;
    bus.out_ready      = 1'b0;
    model_reset();

    @(negedge clk);
    check_output("por_valid", bus.out_valid, 0);
    check_output("por_halted", bus.halted, 0);
    check_output("por_addr", bus.imem_addr, RESET_PC);
    rst_n = 1'b1;

    // Streaming from reset: one idle cycle, then words 0,1,2,...
    apply_stimulus(0, 0, 0, 1);
    check_output("rel_c1_valid", bus.out_valid, 0);
    apply_stimulus(0, 0, 0, 1);
    check_output("rel_c2_valid", bus.out_valid, 1);
    check_output("rel_c2_pc", bus.out_pc, 0);
    apply_stimulus(0, 0, 0, 1);
    check_output("rel_c3_pc", bus.out_pc, 1);
    check_output("rel_c3_instr", bus.out_instr, 1);
    run_until(5);

    // Backpressure at out_pc 5
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0);
      check_output("stall_pc", bus.out_pc, 5);
      check_output("stall_instr", bus.out_instr, 5);
    end
    apply_stimulus(0, 0, 0, 1);
    check_output("after_stall_pc", bus.out_pc, 6);

    // Redirect while stalled flushes the held word
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(1, 40, 0, 0);
    check_output("redir_flush", bus.out_valid, 0);
    apply_stimulus(0, 0, 0, 1);
    check_output("redir_pc0", bus.out_pc, 40);
    apply_stimulus(0, 0, 0, 1);
    check_output("redir_pc1", bus.out_pc, 41);

    // Wrap from DEPTH-1 to 0
    apply_stimulus(1, 60, 0, 1);
    foreach (seq[i]) begin
      apply_stimulus(0, 0, 0, 1);
      check_output("wrap_pc", bus.out_pc, seq[i]);
    end

    // Out-of-range redirect target is reduced modulo DEPTH
    apply_stimulus(1, 200, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("mod_pc", bus.out_pc, 200 % DEPTH);

    // Halt with an unaccepted output, drain it, then resume by redirect
    apply_stimulus(1, 8, 0, 1);
    run_until(10);
    apply_stimulus(0, 0, 1, 0);
    check_output("halt_hold_pc", bus.out_pc, 10);
    check_output("halt_hold_valid", bus.out_valid, 1);
    check_output("halt_flag", bus.halted, 1);
    apply_stimulus(0, 0, 1, 0);
    check_output("halt_hold2_pc", bus.out_pc, 10);
    apply_stimulus(0, 0, 0, 1);
    check_output("halt_drained", bus.out_valid, 0);
    check_output("halt_flag2", bus.halted, 1);
    apply_stimulus(0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("halt_stays", bus.halted, 1);
    apply_stimulus(1, 0, 0, 1);
    check_output("resume_halted", bus.halted, 0);
    check_output("resume_valid", bus.out_valid, 0);
    apply_stimulus(0, 0, 0, 1);
    check_output("resume_pc", bus.out_pc, 0);

    // Reset in the middle of a stall
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    pulse_reset();
    apply_stimulus(0, 0, 0, 1);
    check_output("rst_restart_idle", bus.out_valid, 0);
    apply_stimulus(0, 0, 0, 1);
    check_output("rst_restart_pc", bus.out_pc, RESET_PC);

    // Randomized traffic against the model
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) pulse_reset();
      apply_stimulus($urandom_range(15) == 0, int'($urandom_range(255)),
                     $urandom_range(15) == 0, $urandom_range(9) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
